// File: rtl/bcd_mux7_pkg.sv
// Shared types and seven-segment constants for the multiplexed BCD counter.
package bcd_mux7_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Clamp an out-of-range BCD code to 9
  function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD to seven-segment decode; non-BCD codes are blank.
module seg7_bcd_decode
  import bcd_mux7_pkg::*;
(
  input  bcd_digit_t digit,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (digit)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_counter_mux7.sv
// Prescaled up/down BCD counter with time-multiplexed seven-segment display.
// Optional BCD_LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module bcd_counter_mux7
  import bcd_mux7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned REFRESH    = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [6:0]              seg
);

  localparam int unsigned CNT_W   = 4 * NUM_DIGITS;
  localparam int unsigned PRESC_W = $clog2(PRESCALE);
  localparam int unsigned REF_W   = $clog2(REFRESH);
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [REF_W-1:0]      ref_q, ref_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic [6:0]            seg_q, seg_d;

  logic       tick_c;
  logic       ref_last_c;
  logic       carry_c;
  bcd_digit_t dig_c;
  bcd_digit_t mux_digit_c;
  logic [6:0] dec_seg_c;

  assign tick_c     = run && (presc_q == PRESC_W'(PRESCALE - 1));
  assign ref_last_c = (ref_q == REF_W'(REFRESH - 1));

  // Prescaler: free-runs while run=1, cleared by load
  always_comb begin
    presc_d = presc_q;
    if (load || tick_c) presc_d = '0;
    else if (run)       presc_d = presc_q + PRESC_W'(1);
  end

  // Ripple carry/borrow across digits within one cycle; surviving carry is a full wrap
  always_comb begin
    count_d = count_q;
    carry_c = 1'b1;
    dig_c   = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      dig_c = count_q[4*i +: 4];
      if (load) begin
        count_d[4*i +: 4] = bcd_sat(load_val[4*i +: 4]);
      end else if (tick_c && carry_c) begin
        if (up_dn) begin
          if (dig_c >= 4'd9) count_d[4*i +: 4] = 4'd0;
          else begin
            count_d[4*i +: 4] = dig_c + 4'd1;
            carry_c           = 1'b0;
          end
        end else begin
          if (dig_c == 4'd0) count_d[4*i +: 4] = 4'd9;
          else begin
            count_d[4*i +: 4] = dig_c - 4'd1;
            carry_c           = 1'b0;
          end
        end
      end
    end
    wrap_d = !load && tick_c && carry_c;
  end

  // Display slot rotation, independent of run
  always_comb begin
    ref_d = ref_last_c ? '0 : ref_q + REF_W'(1);
    idx_d = idx_q;
    if (ref_last_c) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    dig_sel_d = NUM_DIGITS'(1) << idx_d;
  end

  always_comb begin
    mux_digit_c = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++)
      if (idx_d == IDX_W'(i)) mux_digit_c = count_q[4*i +: 4];
  end

  seg7_bcd_decode u_decode (
    .digit (mux_digit_c),
    .seg_c (dec_seg_c)
  );

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero_c;
  logic                  above_zero_c;

  // lead_zero_c[i]: digit i and every digit above it are zero; digit 0 always shown
  always_comb begin
    lead_zero_c  = '0;
    above_zero_c = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      above_zero_c   = above_zero_c && (count_q[4*i +: 4] == 4'd0);
      lead_zero_c[i] = above_zero_c;
    end
    lead_zero_c[0] = 1'b0;
    seg_d = (|(lead_zero_c & dig_sel_d)) ? SEG_BLANK : dec_seg_c;
  end
`else
  assign seg_d = dec_seg_c;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q   <= '0;
      ref_q     <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      dig_sel_q <= NUM_DIGITS'(1);
      seg_q     <= SEG_0;
    end else begin
      presc_q   <= presc_d;
      ref_q     <= ref_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      dig_sel_q <= dig_sel_d;
      seg_q     <= seg_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign dig_sel   = dig_sel_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_bcd_counter_mux7.sv
// Bench for bcd_counter_mux7: integer-valued counter/display model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bcd_counter_mux7;

  localparam int ND       = 4;
  localparam int PRESCALE = 4;
  localparam int REFRESH  = 4;
  localparam int MAXV     = 10000;

  logic          clk = 1'b0;
  logic          rst_n, run, up_dn, load;
  logic [15:0]   load_val;
  logic [15:0]   count_bcd;
  logic          wrap;
  logic [3:0]    dig_sel;
  logic [6:0]    seg;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  bcd_counter_mux7 #(.NUM_DIGITS(ND), .PRESCALE(PRESCALE), .REFRESH(REFRESH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .count_bcd (count_bcd),
    .wrap      (wrap),
    .dig_sel   (dig_sel),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic int load_to_int(input logic [15:0] lv);
    int v = 0;
    int d;
    for (int k = 0; k < ND; k++) begin
      d = int'(lv[4*k +: 4]);
      if (d > 9) d = 9;
      v = v + d * pow10(k);
    end
    return v;
  endfunction

  function automatic logic [6:0] seg_of(input int v, input int slot);
    int d = (v / pow10(slot)) % 10;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    if (slot > 0 && v < pow10(slot)) return 7'h00;
`endif
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  default: return 7'h6F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: decimal counter value, prescale phase, refresh phase and display slot
  int         m_count = 0, m_presc = 0, m_ref = 0, m_slot = 0;
  logic       m_wrap  = 1'b0;
  logic [6:0] m_seg   = 7'h3F;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    int new_slot;
    new_slot = (m_ref == REFRESH - 1) ? (m_slot + 1) % ND : m_slot;
    if (!rst_n) begin
      m_count <= 0; m_presc <= 0; m_ref <= 0; m_slot <= 0;
      m_wrap  <= 1'b0; m_seg <= 7'h3F; m_valid <= 1'b1;
    end else begin
      m_ref  <= (m_ref + 1) % REFRESH;
      m_slot <= new_slot;
      m_seg  <= seg_of(m_count, new_slot);
      m_wrap <= 1'b0;
      if (load) begin
        m_count <= load_to_int(load_val);
        m_presc <= 0;
      end else if (run) begin
        if (m_presc == PRESCALE - 1) begin
          m_presc <= 0;
          if (up_dn) begin
            m_count <= (m_count + 1) % MAXV;
            m_wrap  <= (m_count == MAXV - 1);
          end else begin
            m_count <= (m_count + MAXV - 1) % MAXV;
            m_wrap  <= (m_count == 0);
          end
        end else begin
          m_presc <= m_presc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid && !done) begin
      check("cyc_count",   32'(count_bcd), 32'(to_bcd(m_count)));
      check("cyc_wrap",    32'(wrap),      32'(m_wrap));
      check("cyc_dig_sel", 32'(dig_sel),   32'(4'b0001 << m_slot));
      check("cyc_seg",     32'(seg),       32'(m_seg));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [6:0] exp_seg42 [4];
  logic [3:0] ds;

  initial begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
    exp_seg42[0] = 7'h5B; exp_seg42[1] = 7'h66; exp_seg42[2] = 7'h00; exp_seg42[3] = 7'h00;
`else
    exp_seg42[0] = 7'h5B; exp_seg42[1] = 7'h66; exp_seg42[2] = 7'h3F; exp_seg42[3] = 7'h3F;
`endif
    rst_n = 1'b0; run = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    step(2);
    check("rst_count",   32'(count_bcd), 32'h0);
    check("rst_dig_sel", 32'(dig_sel),   32'h1);
    check("rst_seg",     32'(seg),       32'h3F);
    check("rst_wrap",    32'(wrap),      32'h0);

    // Ten ticks counting up from reset
    rst_n = 1'b1; run = 1'b1; up_dn = 1'b1;
    step(40);
    check("up40_count", 32'(count_bcd), 32'h0010);
    check("up40_model", 32'(m_count),   32'd10);

    // Full-range wrap upward
    load = 1'b1; load_val = 16'h9999;
    step(1);
    load = 1'b0;
    step(4);
    check("wrap_up_count", 32'(count_bcd), 32'h0000);
    check("wrap_up_pulse", 32'(wrap),      32'h1);
    step(1);
    check("wrap_up_end",   32'(wrap),      32'h0);
    run = 1'b0;

    // Full-range wrap downward, then plain borrow
    up_dn = 1'b0; load = 1'b1; load_val = 16'h0000; run = 1'b1;
    step(1);
    load = 1'b0;
    step(4);
    check("wrap_dn_count", 32'(count_bcd), 32'h9999);
    check("wrap_dn_pulse", 32'(wrap),      32'h1);
    step(1);
    check("wrap_dn_end",   32'(wrap),      32'h0);
    load = 1'b1; load_val = 16'h1000;
    step(1);
    load = 1'b0;
    step(4);
    check("borrow_count", 32'(count_bcd), 32'h0999);
    check("borrow_wrap",  32'(wrap),      32'h0);
    run = 1'b0;

    // Saturating load and hold with display still rotating
    load = 1'b1; load_val = 16'h00A5;
    step(1);
    load = 1'b0;
    check("sat_load", 32'(count_bcd), 32'h0095);
    step(100);
    check("hold_count", 32'(count_bcd), 32'h0095);
    for (int k = 0; k < 4; k++) begin
      ds = dig_sel;
      step(4);
      check("rotate", 32'(dig_sel), 32'({ds[2:0], ds[3]}));
    end

    // Per-slot segment pattern for 0042
    load = 1'b1; load_val = 16'h0042;
    step(1);
    load = 1'b0;
    step(1);
    for (int k = 0; k < 8 && dig_sel != 4'b0001; k++) step(1);
    check("slot_align", 32'(dig_sel), 32'h1);
    for (int s = 0; s < 4; s++) begin
      check("seg42", 32'(seg), 32'(exp_seg42[s]));
      step(4);
    end

    // Reset during a tick cycle with load asserted
    up_dn = 1'b1; run = 1'b1; load = 1'b1; load_val = 16'h0005;
    step(1);
    load = 1'b0;
    step(3);
    rst_n = 1'b0; load = 1'b1; load_val = 16'h9999;
    step(1);
    rst_n = 1'b1; load = 1'b0; run = 1'b0;
    check("mrst_count",   32'(count_bcd), 32'h0);
    check("mrst_dig_sel", 32'(dig_sel),   32'h1);
    check("mrst_seg",     32'(seg),       32'h3F);
    check("mrst_wrap",    32'(wrap),      32'h0);
    step(1);
    check("mrst_wrap2",   32'(wrap),      32'h0);
    check("mrst_count2",  32'(count_bcd), 32'h0);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_counter_mux7.md
BCD_COUNTER_MUX7 -- requirements
Module: bcd_counter_mux7

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of BCD digits, legal range 1..8.
REQ-002 Parameter PRESCALE, default 1000: clk cycles per count tick, legal range >=2.
REQ-003 Parameter REFRESH, default 256: clk cycles per display digit slot, legal range >=2.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 run  in  1  1 = count on tick; 0 = hold (stop).
REQ-007 up_dn  in  1  1 = count up; 0 = count down.
REQ-008 load  in  1  synchronous load strobe.
REQ-009 load_val  in  4*NUM_DIGITS  BCD load value; digit 0 in bits [3:0].
REQ-010 count_bcd  out  4*NUM_DIGITS  registered current count; digit 0 in bits [3:0].
REQ-011 wrap  out  1  one-cycle pulse on full-range wrap.
REQ-012 dig_sel  out  NUM_DIGITS  registered one-hot, active-high digit enable.
REQ-013 seg  out  7  registered segments {g,f,e,d,c,b,a}, active-high.

Function
REQ-014 Prescaler shall count 0..PRESCALE-1 while run=1, assert internal tick on the cycle it equals PRESCALE-1, then return to 0; it holds while run=0.
REQ-015 On tick with up_dn=1, digit 0 shall increment; a digit at 9 shall go to 0 and carry into the next digit in the same cycle.
REQ-016 On tick with up_dn=0, digit 0 shall decrement; a digit at 0 shall go to 9 and borrow from the next digit in the same cycle.
REQ-017 Full-range wrap: all-9s up -> all-0s, or all-0s down -> all-9s; wrap shall be 1 for exactly the following cycle only.
REQ-018 load=1 shall take priority over tick: count_bcd <= load_val, prescaler <= 0, wrap <= 0.
REQ-019 Any load_val digit greater than 9 shall be loaded as 9.
REQ-020 Count latency: count_bcd changes on the edge following the tick cycle.
REQ-021 Display: a refresh counter 0..REFRESH-1 shall run continuously, independent of run; at REFRESH-1, dig_sel rotates one position toward higher digit index, with the top digit wrapping to digit 0.
REQ-022 seg and dig_sel shall be registered on the same edge; seg is the decode of the count digit selected by the new dig_sel, re-evaluated every cycle so count changes appear within 1 cycle.
REQ-023 Decode (hex {g..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; any other code shall give 00.
REQ-024 up_dn changing mid-count shall take effect at the next tick; no tick shall be lost or duplicated.

Reset
REQ-025 With rst_n=0 at a clk edge: count_bcd=0, prescaler=0, refresh counter=0, wrap=0, dig_sel=1 (digit 0), seg=3F.
REQ-026 Reset shall override load and run, and it applies mid-operation with no residual tick or wrap.

Configuration
REQ-027 Macro BCD_LEADING_ZERO_BLANK_EN defined: seg shall be 00 for any zero digit above the most significant nonzero digit; digit 0 is never blanked.
REQ-028 Macro absent: all digits are always displayed, and no blanking logic shall be present.

Structure
REQ-029 Shared package bcd_mux7_pkg shall hold the segment code constants, the blank code 00, and the BCD digit typedef (4 bits).
REQ-030 The decode shall be a sub-module seg7_bcd_decode (4-bit in, 7-bit out, combinational), instantiated once after the digit mux.

Verification (NUM_DIGITS=4, PRESCALE=4, REFRESH=4)
REQ-031 Reset, then run=1, up_dn=1 for 40 cycles -> count_bcd=0x0010 after the 10th tick; one tick every 4 cycles.
REQ-032 load_val=0x9999 with load, then run up for 1 tick -> count_bcd=0x0000 and wrap high for exactly 1 cycle.
REQ-033 load_val=0x0000, then up_dn=0 for 1 tick -> count_bcd=0x9999 and wrap pulse; load_val=0x1000 down 1 tick -> 0x0999, no wrap.
REQ-034 load_val=0x00A5 -> count_bcd=0x0095; run=0 for 100 cycles -> count unchanged, dig_sel still rotating 1->2->4->8->1 every 4 cycles.
REQ-035 count 0x0042 with macro defined -> seg sequence 5B,66,00,00 over slots 0..3; with macro absent -> 5B,66,3F,3F.
REQ-036 rst_n=0 for 1 cycle during a tick with load=1 -> count_bcd=0, dig_sel=1, seg=3F, wrap=0 next cycle.
